// File: rtl/matrix_op_scheduler.sv
// Matrix datapath sequencer: walks output elements row-major and drives reads, accumulate and writes.
// Optional abort port is compiled in with `define MATRIX_SCHED_ABORT_EN.
module matrix_op_scheduler #(
    parameter int MAX_DIM = 5,
    parameter int DIM_W   = 3,
    parameter int ADDR_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        op_type,
    input  logic [DIM_W-1:0]  dim_m,
    input  logic [DIM_W-1:0]  dim_n,
    input  logic [DIM_W-1:0]  dim_p,
`ifdef MATRIX_SCHED_ABORT_EN
    input  logic              abort,
`endif
    output logic              busy,
    output logic              a_rd_en,
    output logic [ADDR_W-1:0] a_rd_addr,
    output logic              b_rd_en,
    output logic [ADDR_W-1:0] b_rd_addr,
    output logic [2:0]        alu_op,
    output logic              acc_en,
    output logic              acc_clr,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              done,
    output logic              err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_SCL = 3'd2;
    localparam logic [2:0] OP_TRN = 3'd3;
    localparam logic [2:0] OP_MM  = 3'd4;

    logic [1:0]        r_state;
    logic [2:0]        r_op;
    logic [DIM_W-1:0]  r_m, r_n, r_p;
    logic [DIM_W-1:0]  r_i, r_j, r_k;
    logic              r_err;
    logic              r_acc_en, r_acc_clr, r_last;
    logic [ADDR_W-1:0] r_wa_p;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;

    logic              w_abort;
    logic              w_cfg_ok;
    logic [DIM_W-1:0]  w_rows, w_cols, w_klast;
    logic              w_k_end, w_j_end, w_i_end;
    logic              w_issue;
    logic              w_b_use;
    logic [ADDR_W-1:0] w_a_addr, w_b_addr, w_wa;
    logic [ADDR_W-1:0] w_i, w_j, w_k, w_n, w_p, w_c;

`ifdef MATRIX_SCHED_ABORT_EN
    assign w_abort = abort && (r_state == S_RUN || r_state == S_DRAIN);
`else
    assign w_abort = 1'b0;
`endif

    function automatic logic dim_ok(input logic [DIM_W-1:0] d);
        return (d != '0) && (int'(d) <= MAX_DIM);
    endfunction

    assign w_cfg_ok = (op_type <= OP_MM) && dim_ok(dim_m) && dim_ok(dim_n)
                    && ((op_type != OP_MM) || dim_ok(dim_p));

    // Transpose swaps the output shape; only matmul has more than one term
    assign w_rows  = (r_op == OP_TRN) ? r_n : r_m;
    assign w_cols  = (r_op == OP_MM) ? r_p : ((r_op == OP_TRN) ? r_m : r_n);
    assign w_klast = (r_op == OP_MM) ? r_n - DIM_W'(1) : '0;

    assign w_k_end = (r_k == w_klast);
    assign w_j_end = (r_j == w_cols - DIM_W'(1));
    assign w_i_end = (r_i == w_rows - DIM_W'(1));

    assign w_issue = (r_state == S_RUN) && !w_abort;

    assign w_i = ADDR_W'(r_i);
    assign w_j = ADDR_W'(r_j);
    assign w_k = ADDR_W'(r_k);
    assign w_n = ADDR_W'(r_n);
    assign w_p = ADDR_W'(r_p);
    assign w_c = ADDR_W'(w_cols);

    always_comb begin
        w_a_addr = '0;
        w_b_addr = '0;
        w_b_use  = 1'b0;
        unique case (r_op)
            OP_ADD, OP_SUB: begin
                w_a_addr = w_i * w_n + w_j;
                w_b_addr = w_i * w_n + w_j;
                w_b_use  = 1'b1;
            end
            OP_SCL: begin
                w_a_addr = w_i * w_n + w_j;
                w_b_use  = 1'b1;
            end
            OP_TRN: begin
                w_a_addr = w_j * w_n + w_i;
            end
            OP_MM: begin
                w_a_addr = w_i * w_n + w_k;
                w_b_addr = w_k * w_p + w_j;
                w_b_use  = 1'b1;
            end
            default: begin
                w_b_use = 1'b0;
            end
        endcase
    end

    assign w_wa = w_i * w_c + w_j;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_op      <= '0;
            r_m       <= '0;
            r_n       <= '0;
            r_p       <= '0;
            r_i       <= '0;
            r_j       <= '0;
            r_k       <= '0;
            r_err     <= 1'b0;
            r_acc_en  <= 1'b0;
            r_acc_clr <= 1'b0;
            r_last    <= 1'b0;
            r_wa_p    <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
        end else begin
            r_acc_en  <= w_issue;
            r_acc_clr <= w_issue && (r_k == '0);
            r_last    <= w_issue && w_k_end;
            r_wa_p    <= w_wa;
            r_wr_en   <= r_acc_en && r_last && !w_abort;
            r_wr_addr <= r_wa_p;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op <= op_type;
                        r_m  <= dim_m;
                        r_n  <= dim_n;
                        r_p  <= dim_p;
                        r_i  <= '0;
                        r_j  <= '0;
                        r_k  <= '0;
                        if (w_cfg_ok) begin
                            r_err   <= 1'b0;
                            r_state <= S_RUN;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_RUN: begin
                    if (w_abort) begin
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                    end else if (!w_k_end) begin
                        r_k <= r_k + DIM_W'(1);
                    end else begin
                        r_k <= '0;
                        if (!w_j_end) begin
                            r_j <= r_j + DIM_W'(1);
                        end else begin
                            r_j <= '0;
                            if (!w_i_end) begin
                                r_i <= r_i + DIM_W'(1);
                            end else begin
                                r_i     <= '0;
                                r_state <= S_DRAIN;
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_abort) begin
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                    end else if (!r_acc_en) begin
                        r_state <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy      = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign a_rd_en   = w_issue;
    assign a_rd_addr = w_issue ? w_a_addr : '0;
    assign b_rd_en   = w_issue && w_b_use;
    assign b_rd_addr = b_rd_en ? w_b_addr : '0;
    assign alu_op    = r_op;
    assign acc_en    = r_acc_en && !w_abort;
    assign acc_clr   = r_acc_clr && acc_en;
    assign wr_en     = r_wr_en && !w_abort;
    assign wr_addr   = wr_en ? r_wr_addr : '0;
    assign done      = (r_state == S_DONE);
    assign err       = r_err;

endmodule

// File: tb/tb_matrix_op_scheduler.sv
// Directed vector bench for matrix_op_scheduler; define MATRIX_SCHED_ABORT_EN to cover abort.
module tb_matrix_op_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [2:0] op_type = '0;
    logic [2:0] dim_m = '0, dim_n = '0, dim_p = '0;
`ifdef MATRIX_SCHED_ABORT_EN
    logic       abort = 1'b0;
`endif
    logic       busy, a_rd_en, b_rd_en, acc_en, acc_clr, wr_en, done, err;
    logic [4:0] a_rd_addr, b_rd_addr, wr_addr;
    logic [2:0] alu_op;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    matrix_op_scheduler dut (
        .clk(clk), .rst(rst), .start(start), .op_type(op_type),
        .dim_m(dim_m), .dim_n(dim_n), .dim_p(dim_p),
`ifdef MATRIX_SCHED_ABORT_EN
        .abort(abort),
`endif
        .busy(busy), .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr),
        .b_rd_en(b_rd_en), .b_rd_addr(b_rd_addr), .alu_op(alu_op),
        .acc_en(acc_en), .acc_clr(acc_clr), .wr_en(wr_en),
        .wr_addr(wr_addr), .done(done), .err(err)
    );

    typedef struct {
        logic [2:0]       op, m, n, p;
        logic [0:11][4:0] a_seq, b_seq;
        int               nrd, k, buse, nwr, dcyc, err, pert;
    } vec_t;

    vec_t v[10];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int outs_all();
        return int'({busy, a_rd_en, a_rd_addr, b_rd_en, b_rd_addr, alu_op,
                     acc_en, acc_clr, wr_en, wr_addr, done, err});
    endfunction

    task automatic set_vec(input int idx, input logic [2:0] op,
                           input logic [2:0] m, input logic [2:0] n,
                           input logic [2:0] p, input int nrd, input int k,
                           input int buse, input int nwr, input int dcyc,
                           input int e, input int pert);
        v[idx].op = op; v[idx].m = m; v[idx].n = n; v[idx].p = p;
        v[idx].nrd = nrd; v[idx].k = k; v[idx].buse = buse;
        v[idx].nwr = nwr; v[idx].dcyc = dcyc; v[idx].err = e;
        v[idx].pert = pert;
        v[idx].a_seq = '0; v[idx].b_seq = '0;
    endtask

    task automatic run_vec(input int idx);
        int nr, nb, na, nw, dc, ev, lastw;
        vec_t t;
        t = v[idx];
        nr = 0; nb = 0; na = 0; nw = 0; dc = -1; ev = -1; lastw = -1;
        @(negedge clk);
        op_type = t.op; dim_m = t.m; dim_n = t.n; dim_p = t.p; start = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) begin
                chk("busy_t1", busy, t.err == 0);
                chk("err_t1", err, t.err);
            end
            if (a_rd_en) begin
                chk("rd_cycle", c, nr + 1);
                if (nr < 12) chk("a_addr", a_rd_addr, t.a_seq[nr]);
                nr++;
            end
            if (b_rd_en) begin
                if (nb < 12) chk("b_addr", b_rd_addr, t.b_seq[nb]);
                nb++;
            end
            if (acc_en) begin
                chk("acc_clr", acc_clr, (na % t.k) == 0);
                na++;
            end
            if (wr_en) begin
                chk("wr_addr", wr_addr, nw);
                nw++;
                lastw = c;
            end
            if (done) begin
                dc = c;
                ev = err;
                break;
            end
            if (c == 1) start = 1'b0;
            if (t.pert != 0 && c == 2) begin
                start = 1'b1; op_type = 3'd4;
                dim_m = 3'd5; dim_n = 3'd5; dim_p = 3'd5;
            end
            if (c == 3) start = 1'b0;
        end
        start = 1'b0;
        chk("rd_count", nr, t.nrd);
        chk("b_count", nb, (t.buse != 0) ? t.nrd : 0);
        chk("acc_count", na, t.nrd);
        chk("wr_count", nw, t.nwr);
        chk("done_cycle", dc, t.dcyc);
        chk("done_err", ev, t.err);
        if (t.nwr > 0) chk("last_wr_cycle", lastw, t.dcyc - 1);
        @(negedge clk);
        chk("done_pulse", done, 0);
        chk("idle_busy", busy, 0);
        @(negedge clk);
    endtask

    initial begin
        set_vec(0, 3'd0, 3'd2, 3'd3, 3'd0, 6, 1, 1, 6, 9, 0, 0);
        v[0].a_seq = {5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 30'd0};
        v[0].b_seq = v[0].a_seq;
        set_vec(1, 3'd4, 3'd2, 3'd3, 3'd2, 12, 3, 1, 4, 15, 0, 0);
        v[1].a_seq = {5'd0, 5'd1, 5'd2, 5'd0, 5'd1, 5'd2,
                      5'd3, 5'd4, 5'd5, 5'd3, 5'd4, 5'd5};
        v[1].b_seq = {5'd0, 5'd2, 5'd4, 5'd1, 5'd3, 5'd5,
                      5'd0, 5'd2, 5'd4, 5'd1, 5'd3, 5'd5};
        set_vec(2, 3'd3, 3'd2, 3'd3, 3'd0, 6, 1, 0, 6, 9, 0, 0);
        v[2].a_seq = {5'd0, 5'd3, 5'd1, 5'd4, 5'd2, 5'd5, 30'd0};
        set_vec(3, 3'd7, 3'd2, 3'd3, 3'd1, 0, 1, 0, 0, 1, 1, 0);
        set_vec(4, 3'd0, 3'd0, 3'd3, 3'd1, 0, 1, 0, 0, 1, 1, 0);
        set_vec(5, 3'd0, 3'd2, 3'd6, 3'd1, 0, 1, 0, 0, 1, 1, 0);
        set_vec(6, 3'd4, 3'd2, 3'd3, 3'd0, 0, 1, 0, 0, 1, 1, 0);
        set_vec(7, 3'd1, 3'd2, 3'd2, 3'd0, 4, 1, 1, 4, 7, 0, 0);
        v[7].a_seq = {5'd0, 5'd1, 5'd2, 5'd3, 40'd0};
        v[7].b_seq = v[7].a_seq;
        set_vec(8, 3'd2, 3'd1, 3'd1, 3'd0, 1, 1, 1, 1, 4, 0, 1);
        set_vec(9, 3'd0, 3'd2, 3'd3, 3'd0, 6, 1, 1, 6, 9, 0, 1);
        v[9].a_seq = v[0].a_seq;
        v[9].b_seq = v[0].b_seq;

        @(negedge clk);
        chk("reset_outs", outs_all(), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_outs", outs_all(), 0);

        for (int i = 0; i < 10; i++) run_vec(i);

        // Reset in the middle of a 2x3 add, then rerun the full add
        op_type = 3'd0; dim_m = 3'd2; dim_n = 3'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("busy_before_rst", busy, 1);
        rst = 1'b1;
        #1;
        chk("rst_mid_outs", outs_all(), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_vec(0);

`ifdef MATRIX_SCHED_ABORT_EN
        op_type = 3'd0; dim_m = 3'd2; dim_n = 3'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        #1;
        chk("abort_wr_t3", wr_en, 0);
        chk("abort_rd_t3", a_rd_en, 0);
        @(negedge clk);
        abort = 1'b0;
        chk("abort_done", done, 1);
        chk("abort_err", err, 1);
        chk("abort_wr_t4", wr_en, 0);
        chk("abort_acc_t4", acc_en, 0);
        @(negedge clk);
        chk("abort_idle_wr", wr_en, 0);
        chk("abort_idle_done", done, 0);
        @(negedge clk);
        run_vec(0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
